nco_voice_scheduler: RTL

Time-multiplexes one shared NCO/waveform-lookup datapath across NUM_VOICES synth voices. Once per 48 kHz sample period, triggered by the divider's `sample_clk_en` pulse, it does four things:
- Steps each gated voice's phase accumulator.
- Issues one lookup request per voice to the shared datapath.
- Sums the returned samples.
- Delivers one saturated mixed sample to the audio output path.

It sits between the clock divider, the control/config bus and the NCO lookup datapath, all clocked by the 24.576 MHz master clock.

---
 rtl/nco_voice_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nco_voice_scheduler.sv
// Time-multiplexes one shared NCO lookup datapath across NUM_VOICES voices.
// Each sample_clk_en frame issues one lookup per gated voice and emits a saturated mix.
module nco_voice_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_W   = 16
) (
  input  logic                          master_clk,
  input  logic                          rst,
  input  logic                          sample_clk_en,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]            cfg_freq,
  input  logic                          cfg_gate,
  input  logic                          cfg_phase_rst,
  output logic                          nco_req,
  output logic [PHASE_W-1:0]            nco_phase,
  input  logic                          nco_valid,
  input  logic signed [SAMPLE_W-1:0]    nco_sample,
  output logic [SAMPLE_W-1:0]           mix_sample,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + VW;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                    state;
  logic [VW-1:0]             vidx;
  logic signed [ACC_W-1:0]   acc;
  logic [PHASE_W-1:0]        freq  [NUM_VOICES];
  logic [PHASE_W-1:0]        phase [NUM_VOICES];
  logic [NUM_VOICES-1:0]     gate;
  logic                      last_voice;
  logic                      issue_go;
  logic [SAMPLE_W-1:0]       sat_sample;

  assign last_voice = (vidx == VW'(NUM_VOICES - 1));
  assign issue_go   = (state == ISSUE) && gate[vidx];

  // The request is decoded from registered state so the lookup starts in the ISSUE cycle itself.
  assign nco_req   = issue_go;
  assign nco_phase = issue_go ? phase[vidx] : '0;

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the voice tables are reset on purpose: every voice must come up silent at phase 0.
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq[v]  <= '0;
        phase[v] <= '0;
      end
      gate <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_we && cfg_voice == VW'(v)) begin
          freq[v] <= cfg_freq;
          gate[v] <= cfg_gate;
        end
        // A phase clear from the bus overrides the accumulator step for the same voice.
        if (cfg_we && cfg_phase_rst && cfg_voice == VW'(v))
          phase[v] <= '0;
        else if (issue_go && vidx == VW'(v))
          phase[v] <= phase[v] + freq[v];
      end
    end
  end

  always_comb begin
    // NOTE: default assignment first, so every path drives sat_sample and no latch is inferred.
    sat_sample = acc[SAMPLE_W-1:0];
    if (acc > SAT_MAX)
      sat_sample = SAT_MAX[SAMPLE_W-1:0];
    else if (acc < SAT_MIN)
      sat_sample = SAT_MIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      vidx       <= '0;
      acc        <= '0;
      mix_sample <= '0;
      mix_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (sample_clk_en && busy)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_clk_en) begin
            state <= ISSUE;
            vidx  <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (gate[vidx])
            state <= WAIT;
          else if (last_voice)
            state <= DONE;
          else
            vidx <= vidx + VW'(1);
        end
        WAIT: begin
          if (nco_valid) begin
            acc <= acc + {{VW{nco_sample[SAMPLE_W-1]}}, nco_sample};
            if (last_voice) begin
              state <= DONE;
            end else begin
              state <= ISSUE;
              vidx  <= vidx + VW'(1);
            end
          end
        end
        DONE: begin
          mix_sample <= sat_sample;
          mix_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
